// File: rtl/booth_div_pkg.sv
// Shared types and helpers for the sequential non-restoring divider.
// Provides the FSM state encoding and the operand magnitude helper.
package booth_div_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ITER,
        FIX,
        DONE
    } div_state_t;

    // Caller passes the operand already sign-extended to 64 bits, so the
    // result holds the exact magnitude even for the most-negative value.
    function automatic logic [63:0] abs_ext(
        input logic [63:0] value,
        input logic        signed_mode
    );
        return (signed_mode && value[63]) ? -value : value;
    endfunction

endpackage

// File: rtl/booth_div_step.sv
// One combinational non-restoring division step.
// Ports: p (partial remainder), d_mag, bit_in -> p_next, q_bit.
module booth_div_step #(
    parameter int WIDTH_D = 4
) (
    input  logic signed [WIDTH_D:0] p,
    input  logic        [WIDTH_D:0] d_mag,
    input  logic                    bit_in,
    output logic signed [WIDTH_D:0] p_next,
    output logic                    q_bit
);

    logic signed [WIDTH_D+1:0] shifted;
    logic signed [WIDTH_D+1:0] sum;

    always_comb begin
        // 2P + bit needs one extra bit; the sum always fits back in WIDTH_D+1.
        shifted = {p, bit_in};
        if (p[WIDTH_D]) begin
            sum = shifted + $signed({1'b0, d_mag});
        end else begin
            sum = shifted - $signed({1'b0, d_mag});
        end
        p_next = sum[WIDTH_D:0];
        q_bit  = ~sum[WIDTH_D+1];
    end

endmodule

// File: rtl/booth_div_seq.sv
// Sequential non-restoring divider, one quotient bit per cycle plus a sign-fix cycle.
// Ports: clk, rst, vld_in, dividend, divisor -> quotient, remainder, done, busy, div_by_zero.
module booth_div_seq
    import booth_div_pkg::*;
#(
    parameter int WIDTH_N = 4,
    parameter int WIDTH_D = 4,
    parameter bit SIGNED  = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               vld_in,
    input  logic [WIDTH_N-1:0] dividend,
    input  logic [WIDTH_D-1:0] divisor,
    output logic [WIDTH_N-1:0] quotient,
    output logic [WIDTH_D-1:0] remainder,
    output logic               done,
    output logic               busy,
    output logic               div_by_zero
);

    localparam int CW = $clog2(WIDTH_N);

    div_state_t state_q, state_d;
    logic [CW-1:0]             cnt_q, cnt_d;
    logic [WIDTH_N-1:0]        nq_q, nq_d;
    logic signed [WIDTH_D:0]   p_q, p_d;
    logic [WIDTH_D:0]          dmag_q, dmag_d;
    logic [WIDTH_D-1:0]        dlo_q, dlo_d;
    logic                      negq_q, negq_d;
    logic                      negr_q, negr_d;
    logic                      dz_q, dz_d;
    logic [WIDTH_N-1:0]        quo_q, quo_d;
    logic [WIDTH_D-1:0]        rem_q, rem_d;
    logic                      done_q, done_d;

    logic                      sn, sd;
    logic [63:0]               n_abs, d_abs;
    logic signed [WIDTH_D:0]   p_step, p_fix;
    logic [WIDTH_D-1:0]        rem_mag;
    logic                      q_bit;

    // Dividend magnitude shifts out MSB-first while quotient bits shift
    // in at the bottom, so nq_q ends up holding |quotient|.
    booth_div_step #(
        .WIDTH_D(WIDTH_D)
    ) u_step (
        .p     (p_q),
        .d_mag (dmag_q),
        .bit_in(nq_q[WIDTH_N-1]),
        .p_next(p_step),
        .q_bit (q_bit)
    );

    always_comb begin
        sn    = SIGNED && dividend[WIDTH_N-1];
        sd    = SIGNED && divisor[WIDTH_D-1];
        n_abs = abs_ext({{(64-WIDTH_N){sn}}, dividend}, SIGNED);
        d_abs = abs_ext({{(64-WIDTH_D){sd}}, divisor}, SIGNED);
        p_fix = p_q[WIDTH_D] ? p_q + $signed(dmag_q) : p_q;
        rem_mag = p_fix[WIDTH_D-1:0];
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        nq_d    = nq_q;
        p_d     = p_q;
        dmag_d  = dmag_q;
        dlo_d   = dlo_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        dz_d    = dz_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (vld_in) begin
                    state_d = ITER;
                    cnt_d   = CW'(WIDTH_N-1);
                    nq_d    = n_abs[WIDTH_N-1:0];
                    dmag_d  = d_abs[WIDTH_D:0];
                    p_d     = '0;
                    dlo_d   = dividend[WIDTH_D-1:0];
                    negq_d  = sn ^ sd;
                    negr_d  = sn;
                    dz_d    = (divisor == '0);
                end
            end
            ITER: begin
                p_d   = p_step;
                nq_d  = {nq_q[WIDTH_N-2:0], q_bit};
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                if (dz_q) begin
                    quo_d = '1;
                    rem_d = dlo_q;
                end else begin
                    quo_d = negq_q ? -nq_q : nq_q;
                    rem_d = negr_q ? -rem_mag : rem_mag;
                end
                state_d = DONE;
            end
            DONE: begin
                // done is registered, so the pulse appears the cycle after DONE.
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            nq_q    <= '0;
            p_q     <= '0;
            dmag_q  <= '0;
            dlo_q   <= '0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            dz_q    <= 1'b0;
            quo_q   <= '0;
            rem_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            nq_q    <= nq_d;
            p_q     <= p_d;
            dmag_q  <= dmag_d;
            dlo_q   <= dlo_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            dz_q    <= dz_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            done_q  <= done_d;
        end
    end

    assign quotient    = quo_q;
    assign remainder   = rem_q;
    assign done        = done_q;
    assign busy        = (state_q != IDLE);
    assign div_by_zero = dz_q;

endmodule

// File: tb/tb_booth_div_seq.sv
// Bench for booth_div_seq: signed and unsigned instances share one stimulus bus.
// A plain-arithmetic model predicts timing and results; directed ops pin literals.
module tb_booth_div_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       vld_in = 1'b0;
    logic [3:0] dividend = 4'h0;
    logic [3:0] divisor = 4'h0;

    logic [3:0] q_s, r_s, q_u, r_u;
    logic       done_s, busy_s, dz_s;
    logic       done_u, busy_u, dz_u;

    int checks = 0;
    int passed = 0;

    booth_div_seq #(.WIDTH_N(4), .WIDTH_D(4), .SIGNED(1'b1)) dut_s (
        .clk(clk), .rst(rst), .vld_in(vld_in),
        .dividend(dividend), .divisor(divisor),
        .quotient(q_s), .remainder(r_s), .done(done_s),
        .busy(busy_s), .div_by_zero(dz_s)
    );

    booth_div_seq #(.WIDTH_N(4), .WIDTH_D(4), .SIGNED(1'b0)) dut_u (
        .clk(clk), .rst(rst), .vld_in(vld_in),
        .dividend(dividend), .divisor(divisor),
        .quotient(q_u), .remainder(r_u), .done(done_u),
        .busy(busy_u), .div_by_zero(dz_u)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] qs, rs, qu, ru;
        logic       dzs, dzu;
        int         due;
    } exp_t;

    exp_t expq[$];
    exp_t last;
    exp_t e;
    int   edge_n = 0;
    int   free_at = 0;
    logic exp_done, exp_busy;

    function automatic void ref_div(input logic [3:0] n, input logic [3:0] d,
                                    input bit sgn, output logic [3:0] q,
                                    output logic [3:0] r, output logic dz);
        int nv, dv;
        nv = sgn ? int'($signed(n)) : int'(n);
        dv = sgn ? int'($signed(d)) : int'(d);
        dz = (dv == 0);
        if (dz) begin
            q = 4'hF;
            r = n;
        end else begin
            q = 4'(nv / dv);
            r = 4'(nv % dv);
        end
    endfunction

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h want %h (edge %0d)", name, act, exp, edge_n);
    endtask

    // Model: an idle divider accepts on any edge with vld_in, is busy for
    // 6 cycles, pulses done after the 6th edge, and is free again at the 7th.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            expq.delete();
            free_at = 0;
            last = '{qs: 4'h0, rs: 4'h0, qu: 4'h0, ru: 4'h0, dzs: 1'b0, dzu: 1'b0, due: 0};
        end else begin
            edge_n++;
            if (vld_in && edge_n >= free_at) begin
                ref_div(dividend, divisor, 1'b1, e.qs, e.rs, e.dzs);
                ref_div(dividend, divisor, 1'b0, e.qu, e.ru, e.dzu);
                e.due = edge_n + 6;
                expq.push_back(e);
                free_at = edge_n + 7;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            exp_done = (expq.size() > 0) && (expq[0].due == edge_n);
            exp_busy = edge_n < free_at - 1;
            chk("done_s", {3'b0, done_s}, {3'b0, exp_done});
            chk("done_u", {3'b0, done_u}, {3'b0, exp_done});
            chk("busy_s", {3'b0, busy_s}, {3'b0, exp_busy});
            chk("busy_u", {3'b0, busy_u}, {3'b0, exp_busy});
            if (exp_done) last = expq.pop_front();
            if (exp_done || !exp_busy) begin
                chk("q_s", q_s, last.qs);
                chk("r_s", r_s, last.rs);
                chk("dz_s", {3'b0, dz_s}, {3'b0, last.dzs});
                chk("q_u", q_u, last.qu);
                chk("r_u", r_u, last.ru);
                chk("dz_u", {3'b0, dz_u}, {3'b0, last.dzu});
            end
        end
    end

    task automatic wait_done(output int k);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!done_s && k < 20);
        if (!done_s) begin
            checks++;
            $display("FAIL wait_done: no done within %0d cycles", k);
        end
    endtask

    task automatic run_op(input logic [3:0] n, input logic [3:0] d,
                          input logic [3:0] qs, input logic [3:0] rs,
                          input logic [3:0] qu, input logic [3:0] ru,
                          input logic dz);
        int k;
        @(negedge clk);
        vld_in = 1'b1;
        dividend = n;
        divisor = d;
        @(negedge clk);
        vld_in = 1'b0;
        dividend = ~n;
        divisor = ~d;
        wait_done(k);
        checks++;
        if (k == 6) passed++;
        else $display("FAIL latency %h/%h: got %0d edges want 6", n, d, k);
        chk("lit_q_s", q_s, qs);
        chk("lit_r_s", r_s, rs);
        chk("lit_q_u", q_u, qu);
        chk("lit_r_u", r_u, ru);
        chk("lit_dz_s", {3'b0, dz_s}, {3'b0, dz});
        chk("lit_dz_u", {3'b0, dz_u}, {3'b0, dz});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int k;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_q_s", q_s, 4'h0);
        chk("rst_r_s", r_s, 4'h0);
        chk("rst_busy", {3'b0, busy_s}, 4'h0);
        chk("rst_done", {3'b0, done_s}, 4'h0);
        @(negedge clk);
        rst = 1'b0;

        // args: n, d, signed q/r, unsigned q/r, div_by_zero
        run_op(4'h7, 4'h2, 4'h3, 4'h1, 4'h3, 4'h1, 1'b0);
        run_op(4'h9, 4'h2, 4'hD, 4'hF, 4'h4, 4'h1, 1'b0);
        run_op(4'h7, 4'hE, 4'hD, 4'h1, 4'h0, 4'h7, 1'b0);
        run_op(4'h9, 4'hE, 4'h3, 4'hF, 4'h0, 4'h9, 1'b0);
        run_op(4'h8, 4'hF, 4'h8, 4'h0, 4'h0, 4'h8, 1'b0);
        run_op(4'h8, 4'h1, 4'h8, 4'h0, 4'h8, 4'h0, 1'b0);
        run_op(4'h5, 4'h0, 4'hF, 4'h5, 4'hF, 4'h5, 1'b1);
        run_op(4'h6, 4'h3, 4'h2, 4'h0, 4'h2, 4'h0, 1'b0);
        run_op(4'hF, 4'h4, 4'h0, 4'hF, 4'h3, 4'h3, 1'b0);

        @(negedge clk);
        vld_in = 1'b1;
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                dividend = 4'(a);
                divisor = 4'(b);
                wait_done(k);
            end
        end
        vld_in = 1'b0;

        run_op(4'h7, 4'h2, 4'h3, 4'h1, 4'h3, 4'h1, 1'b0);
        @(negedge clk);
        vld_in = 1'b1;
        dividend = 4'h9;
        divisor = 4'h3;
        @(negedge clk);
        vld_in = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_q_s", q_s, 4'h0);
        chk("arst_r_s", r_s, 4'h0);
        chk("arst_q_u", q_u, 4'h0);
        chk("arst_r_u", r_u, 4'h0);
        chk("arst_busy_s", {3'b0, busy_s}, 4'h0);
        chk("arst_busy_u", {3'b0, busy_u}, 4'h0);
        chk("arst_done", {3'b0, done_s}, 4'h0);
        chk("arst_dz", {3'b0, dz_s}, 4'h0);
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        run_op(4'h6, 4'h3, 4'h2, 4'h0, 4'h2, 4'h0, 1'b0);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
